// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Widths derive from NUM_BLOCKS, BLOCK_WORDS and ADDR_W.
package icache_pkg;

  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int ADDR_W      = 10;

  localparam int OFFSET_W  = $clog2(BLOCK_WORDS);
  localparam int INDEX_W   = $clog2(NUM_BLOCKS);
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int BLOCK_W   = 32 * BLOCK_WORDS;
  localparam int BLKADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port,
// one synchronous write port, valid bits cleared asynchronously.
module icache_line_array
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INDEX_W-1:0] RD_INDEX,
  output logic               RD_VALID,
  output logic [TAG_W-1:0]   RD_TAG,
  output logic [BLOCK_W-1:0] RD_DATA,
  input  logic               WR_EN,
  input  logic [INDEX_W-1:0] WR_INDEX,
  input  logic [TAG_W-1:0]   WR_TAG,
  input  logic [BLOCK_W-1:0] WR_DATA
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  // Valid bits: cleared on reset, set when a line is refilled.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
    end else if (WR_EN) begin
      valid_q[WR_INDEX] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the valid bit is set.
  always_ff @(posedge CLK) begin
    if (WR_EN) begin
      tag_q[WR_INDEX]  <= WR_TAG;
      data_q[WR_INDEX] <= WR_DATA;
    end
  end

  assign RD_VALID = valid_q[RD_INDEX];
  assign RD_TAG   = tag_q[RD_INDEX];
  assign RD_DATA  = data_q[RD_INDEX];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with block refill FSM.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module instr_cache
  import icache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [ADDR_W-1:0]    ADDRESS,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic [BLKADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]   MEM_READDATA,
  input  logic                 MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]          HIT_COUNT,
  output logic [15:0]          MISS_COUNT
`endif
);

  icache_state_t state_q, state_d;

  logic [BLKADDR_W-1:0] miss_q;
  logic [BLOCK_W-1:0]   fill_q;

  logic [OFFSET_W-1:0]  offset;
  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [BLOCK_W-1:0]   rd_data;
  logic                 hit;
  logic                 wr_en;

  logic                 latch_miss;
  logic                 capture;

  assign offset = ADDRESS[OFFSET_W+1:2];
  assign index  = ADDRESS[OFFSET_W+2 +: INDEX_W];
  assign tag    = ADDRESS[ADDR_W-1 -: TAG_W];

  icache_line_array u_lines (
    .CLK      (CLK),
    .RESET    (RESET),
    .RD_INDEX (index),
    .RD_VALID (rd_valid),
    .RD_TAG   (rd_tag),
    .RD_DATA  (rd_data),
    .WR_EN    (wr_en),
    .WR_INDEX (miss_q[INDEX_W-1:0]),
    .WR_TAG   (miss_q[BLKADDR_W-1 -: TAG_W]),
    .WR_DATA  (fill_q)
  );

  assign hit = rd_valid && (rd_tag == tag);

  // Word select out of the indexed line.
  always_comb begin
    INSTRUCTION = '0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      if (offset == OFFSET_W'(w)) begin
        INSTRUCTION = rd_data[32*w +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    BUSYWAIT   = 1'b1;
    MEM_READ   = 1'b0;
    wr_en      = 1'b0;
    latch_miss = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        BUSYWAIT = !hit;
        if (!hit) begin
          latch_miss = 1'b1;
          state_d    = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          capture = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        wr_en   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Miss block address and captured fill data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss_q <= '0;
      fill_q <= '0;
    end else begin
      if (latch_miss) begin
        miss_q <= {tag, index};
      end
      if (capture) begin
        fill_q <= MEM_READDATA;
      end
    end
  end

  assign MEM_ADDRESS = miss_q;

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters sampled in IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else if (state_q == S_IDLE) begin
      if (hit && HIT_COUNT != 16'hFFFF) begin
        HIT_COUNT <= HIT_COUNT + 16'd1;
      end
      if (!hit && MISS_COUNT != 16'hFFFF) begin
        MISS_COUNT <= MISS_COUNT + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Directed table-driven bench for instr_cache with a
// busy-wait block memory model of configurable latency.
module tb_instr_cache;

  logic         CLK;
  logic         RESET;
  logic [9:0]   ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  instr_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [7:0] wa);
    return {16'hC0DE, 8'h5A, wa};
  endfunction

  int mem_lat;
  int mem_cnt;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) mem_cnt <= 0;
    else if (MEM_READ) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  always_comb begin
    MEM_BUSYWAIT = !(MEM_READ && (mem_cnt >= mem_lat - 1));
  end

  always_comb begin
    MEM_READDATA = '0;
    for (int w = 0; w < 4; w++) begin
      MEM_READDATA[32*w +: 32] = mem_word({MEM_ADDRESS, 2'(w)});
    end
  end

  typedef struct {
    logic [9:0]  addr;
    int          lat;
    logic        busy;
    logic        mrd;
    logic [5:0]  maddr;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_row(input logic [9:0] a, input int lat,
                         input logic busy, input logic mrd);
    vec_t v;
    v.addr  = a;
    v.lat   = lat;
    v.busy  = busy;
    v.mrd   = mrd;
    v.maddr = a[9:4];
    v.instr = mem_word(a[9:2]);
    vecs.push_back(v);
  endtask

  task automatic add_hit(input logic [9:0] a);
    add_row(a, 1, 1'b0, 1'b0);
  endtask

  task automatic add_miss(input logic [9:0] a, input int lat);
    int n;
    n = (lat <= 1) ? 1 : lat;
    add_row(a, lat, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) add_row(a, lat, 1'b1, 1'b1);
    add_row(a, lat, 1'b1, 1'b0);
    add_hit(a);
  endtask

  int stats_row;

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    mem_lat = 1;
    RESET   = 1'b1;
    ADDRESS = 10'h000;

    add_miss(10'h000, 5);
    add_hit(10'h004);
    add_hit(10'h008);
    add_hit(10'h00C);
    stats_row = vecs.size();
    add_miss(10'h010, 2);
    add_miss(10'h090, 2);
    add_miss(10'h010, 1);
    add_miss(10'h3FC, 0);
    add_hit(10'h3F0);
    add_hit(10'h004);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busywait", 32'(BUSYWAIT), 32'd1);
    chk("reset_mem_read", 32'(MEM_READ), 32'd0);
    chk("reset_mem_addr", 32'(MEM_ADDRESS), 32'd0);
`ifdef ICACHE_STATS_EN
    chk("reset_hits", 32'(HIT_COUNT), 32'd0);
    chk("reset_misses", 32'(MISS_COUNT), 32'd0);
`endif

    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      ADDRESS = vecs[i].addr;
      mem_lat = vecs[i].lat;
      @(negedge CLK);
      chk($sformatf("row%0d_busy", i), 32'(BUSYWAIT), 32'(vecs[i].busy));
      chk($sformatf("row%0d_mrd", i), 32'(MEM_READ), 32'(vecs[i].mrd));
      if (vecs[i].mrd)
        chk($sformatf("row%0d_maddr", i), 32'(MEM_ADDRESS),
            32'(vecs[i].maddr));
      if (!vecs[i].busy)
        chk($sformatf("row%0d_instr", i), INSTRUCTION, vecs[i].instr);
`ifdef ICACHE_STATS_EN
      if (i == stats_row) begin
        chk("stats_hits", 32'(HIT_COUNT), 32'd4);
        chk("stats_misses", 32'(MISS_COUNT), 32'd1);
      end
`endif
      @(posedge CLK);
      #1;
    end

    ADDRESS = 10'h200;
    mem_lat = 5;
    @(negedge CLK);
    chk("midfill_miss", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    chk("midfill_mrd_before", 32'(MEM_READ), 32'd1);
    RESET = 1'b1;
    #1;
    chk("midfill_mrd_drop", 32'(MEM_READ), 32'd0);
    chk("midfill_busy", 32'(BUSYWAIT), 32'd1);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("midfill_line_invalid", 32'(BUSYWAIT), 32'd1);
    chk("midfill_idle", 32'(MEM_READ), 32'd0);
    @(posedge CLK);
    #1;
    chk("refetch_mrd", 32'(MEM_READ), 32'd1);
    chk("refetch_maddr", 32'(MEM_ADDRESS), 32'h20);
    for (int c = 0; c < 20 && BUSYWAIT; c++) begin
      @(posedge CLK);
      #1;
    end
    chk("refetch_done", 32'(BUSYWAIT), 32'd0);
    chk("refetch_instr", INSTRUCTION, mem_word(8'h80));
    ADDRESS = 10'h000;
    #1;
    chk("line0_cleared", 32'(BUSYWAIT), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache placed between the CPU's fetch port (PC in, INSTRUCTION out) and the word-organised instruction memory. It serves hits combinationally in the same cycle. On a miss it raises BUSYWAIT to stall the PC register. It then fetches a whole block from instruction memory through a busy-wait handshake and refills the line.

## Interface
- NUM_BLOCKS, 8, number of cache lines; power of two.
- BLOCK_WORDS, 4, 32-bit words per line; power of two.
- ADDR_W, 10, byte-address width used from PC (1024-byte instruction space).
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDRESS  input  ADDR_W  byte address of the fetch (PC[ADDR_W-1:0]); bits [1:0] ignored.
- INSTRUCTION  output  32  fetched word; valid when BUSYWAIT low.
- BUSYWAIT  output  1  high while the requested word is not available; CPU holds PC.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  ADDR_W-log2(4*BLOCK_WORDS)  block address = {tag, index}.
- MEM_READDATA  input  32*BLOCK_WORDS  block data; word w at bits [32w+31:32w].
- MEM_BUSYWAIT  input  1  memory busy; data valid in the cycle it is low while MEM_READ high.

## Operation
- Address split (defaults): offset ADDRESS[3:2] selects the word. Index ADDRESS[6:4] selects the line. Tag is ADDRESS[9:7].
- Per line: valid bit, tag, data block.
- Hit = valid[index] && tag[index]==tag. On a hit, INSTRUCTION = selected word and BUSYWAIT=0.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE: on a miss, BUSYWAIT=1. At the next rising edge, latch {tag,index} into a miss register and go to MEM_READ.
- MEM_READ: MEM_READ=1, MEM_ADDRESS=latched block address, BUSYWAIT=1. Stay while MEM_BUSYWAIT=1. At the first rising edge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
- UPDATE: at the rising edge, write data, tag, and valid=1 into the latched index. MEM_READ=0 and BUSYWAIT=1 during this state. Then go to IDLE, where the lookup hits.
- The CPU holds ADDRESS stable while BUSYWAIT=1. The refill always uses the latched address, so it is unaffected by any ADDRESS glitch.
- A refill overwrites the line unconditionally; there is no dirty state and no write path.
- The cache never issues speculative or back-to-back requests. MEM_READ drops for at least the UPDATE cycle between fills.

## Timing
- Reset (asynchronous): state=IDLE, all valid=0, MEM_READ=0, MEM_ADDRESS=0, miss register=0. BUSYWAIT then follows the combinational lookup, so it is high because every lookup misses. INSTRUCTION is don't-care while BUSYWAIT is high.
- Hit latency: 0 cycles. ADDRESS→INSTRUCTION/BUSYWAIT is a combinational path.
- Miss penalty: 1 (IDLE→MEM_READ) + N (memory busy cycles, N≥1 including the data cycle) + 1 (UPDATE) cycles before BUSYWAIT falls.
- Reset during MEM_READ or UPDATE: the fill is abandoned and no line is written. MEM_READ drops immediately. Memory must tolerate withdrawal of MEM_READ.
- MEM_BUSYWAIT low in the first MEM_READ cycle is legal and gives a 1-cycle memory phase.
- Index wrap: lines 0..NUM_BLOCKS-1 map modulo the block address. Address 0x3FC maps to index 7, tag 7, word 3.

## Configuration
- ICACHE_STATS_EN defined: adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both cleared by RESET.
  - HIT_COUNT increments once per rising edge in IDLE with a hit.
  - MISS_COUNT increments once per IDLE→MEM_READ transition.
  - Both saturate at 16'hFFFF.
- ICACHE_STATS_EN undefined: ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package icache_pkg: FSM state encoding (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2), and derived widths OFFSET_W, INDEX_W, TAG_W, BLOCK_W.
- One sub-module: icache_line_array, holding the valid/tag/data storage. It has one combinational read port and one synchronous write port, and its valid bits are cleared asynchronously.
- The FSM, the miss register, and the optional counters live in instr_cache.

## Test plan
- Cold miss: reset, ADDRESS=0x000, memory latency 5 cycles → BUSYWAIT high 7 cycles. MEM_ADDRESS=0 while MEM_READ. Then INSTRUCTION = word 0 of the block.
- Sequential hits: after the fill, ADDRESS 0x004, 0x008, 0x00C → BUSYWAIT=0 each cycle, words 1..3 returned, MEM_READ stays 0.
- Conflict eviction: fetch 0x010 (index 1, tag 0), then 0x090 (index 1, tag 1) → second access misses with MEM_ADDRESS=0x09. A re-fetch of 0x010 misses again.
- Reset mid-fill: assert RESET in the 2nd MEM_READ cycle → MEM_READ=0 immediately, state IDLE. The next fetch of the same address misses, proving the line is not valid.
- Zero-latency memory: MEM_BUSYWAIT tied low → miss penalty exactly 3 cycles.
- With ICACHE_STATS_EN: run the cold-miss and sequential-hits scenarios → MISS_COUNT=1, HIT_COUNT=4.
